// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: sweeps read port 1 of the 32x32 register file and streams
// the whole file out of an 8N1 UART. The stream is a sync header followed by
// x0..x31, with each register sent as 4 bytes, most significant byte first.
module regfile_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  a1,
  input  logic [31:0] rd1,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned idx_w  = 5;
  localparam int unsigned byte_w = 2;
  localparam int unsigned bit_w  = 4;
  localparam int unsigned baud_w = 16;
  localparam int unsigned word_w = 32;

  localparam logic [baud_w-1:0] baud_last = baud_w'(CLKS_PER_BIT - 1);
  localparam logic [bit_w-1:0]  bit_stop  = bit_w'(9);
  localparam logic [byte_w-1:0] byte_last = byte_w'(3);
  localparam logic [idx_w-1:0]  idx_last  = idx_w'(31);

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_hdr   = 3'd1;
  localparam logic [2:0] st_fetch = 3'd2;
  localparam logic [2:0] st_send  = 3'd3;
  localparam logic [2:0] st_done  = 3'd4;

  logic [2:0]        state,    state_nxt;
  logic [idx_w-1:0]  idx,      idx_nxt;
  logic [byte_w-1:0] byte_cnt, byte_nxt;
  logic [bit_w-1:0]  bit_cnt,  bit_nxt;
  logic [baud_w-1:0] baud,     baud_nxt;
  logic [word_w-1:0] word,     word_nxt;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [4:0]        a1_nxt;
  logic              bit_end;
  logic [7:0]        tx_byte;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, counters, and the next value of every registered output
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    byte_nxt  = byte_cnt;
    bit_nxt   = bit_cnt;
    baud_nxt  = baud;
    word_nxt  = word;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    a1_nxt    = '0;
    tx_byte   = HEADER;
    bit_end   = (baud == baud_last);

    case (state)
      st_idle: begin
        if (start) begin
          state_nxt = st_hdr;
          idx_nxt   = '0;
          byte_nxt  = '0;
          bit_nxt   = '0;
          baud_nxt  = '0;
        end
      end

      st_hdr: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == bit_stop) begin
            state_nxt = st_fetch;
            idx_nxt   = '0;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + bit_w'(1);
          end
        end else begin
          baud_nxt = baud + baud_w'(1);
        end
      end

      // rd1 is captured only here, so later writes cannot disturb the word in flight
      st_fetch: begin
        state_nxt = st_send;
        word_nxt  = rd1;
        byte_nxt  = '0;
        bit_nxt   = '0;
        baud_nxt  = '0;
      end

      st_send: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == bit_stop) begin
            bit_nxt = '0;
            if (byte_cnt == byte_last) begin
              byte_nxt = '0;
              if (idx == idx_last) begin
                state_nxt = st_done;
              end else begin
                state_nxt = st_fetch;
                idx_nxt   = idx + idx_w'(1);
              end
            end else begin
              byte_nxt = byte_cnt + byte_w'(1);
            end
          end else begin
            bit_nxt = bit_cnt + bit_w'(1);
          end
        end else begin
          baud_nxt = baud + baud_w'(1);
        end
      end

      st_done: begin
        state_nxt = st_idle;
        idx_nxt   = '0;
      end

      default: begin
        state_nxt = st_idle;
      end
    endcase

    // Byte on the line for the upcoming cycle
    if (state_nxt == st_send) begin
      case (byte_nxt)
        2'd0:    tx_byte = word_nxt[31:24];
        2'd1:    tx_byte = word_nxt[23:16];
        2'd2:    tx_byte = word_nxt[15:8];
        default: tx_byte = word_nxt[7:0];
      endcase
    end

    // Frame bit: 0 = start, 1..8 = data LSB first, 9 = stop
    if ((state_nxt == st_hdr) || (state_nxt == st_send)) begin
      if (bit_nxt == '0) begin
        tx_nxt = 1'b0;
      end else if (bit_nxt == bit_stop) begin
        tx_nxt = 1'b1;
      end else begin
        tx_nxt = tx_byte[3'(bit_nxt - bit_w'(1))];
      end
    end

    busy_nxt = (state_nxt == st_hdr) || (state_nxt == st_fetch) ||
               (state_nxt == st_send);
    done_nxt = (state_nxt == st_done);

    // a1 follows the register index only while that register is fetched and sent
    if ((state_nxt == st_fetch) || (state_nxt == st_send)) begin
      a1_nxt = idx_nxt;
    end
  end

  // Datapath counters, captured word and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      word     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      a1       <= '0;
    end else begin
      idx      <= idx_nxt;
      byte_cnt <= byte_nxt;
      bit_cnt  <= bit_nxt;
      baud     <= baud_nxt;
      word     <= word_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      a1       <= a1_nxt;
    end
  end

endmodule
